// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: the decoded opcode set,
// the controller state and unit-select encodings, default timing limits,
// and the opcode-to-unit routing function.
package issue_ctrl_pkg;

  // Decoded operation. Codes 4'hA..4'hF are undefined and are routed to the ALU.
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_MUL   = 4'h3,
    OP_SF1   = 4'h4,
    OP_SF2   = 4'h5,
    OP_SF3   = 4'h6,
    OP_SF4   = 4'h7,
    OP_LOAD  = 4'h8,
    OP_STORE = 4'h9
  } opcode;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_END = 2'd1,
    DRAIN    = 2'd2,
    RESP     = 2'd3
  } issue_state_t;

  typedef enum logic [1:0] {
    U_ALU   = 2'd0,
    U_LOAD  = 2'd1,
    U_STORE = 2'd2
  } unit_sel_t;

  localparam int ISSUE_TIMEOUT   = 64;
  localparam int ISSUE_DRAIN_MAX = 3;

  // LOAD and STORE have dedicated units; everything else (NOP and
  // undefined codes included) goes to the ALU.
  function automatic unit_sel_t unit_of(input opcode op);
    case (op)
      OP_LOAD:  return U_LOAD;
      OP_STORE: return U_STORE;
      default:  return U_ALU;
    endcase
  endfunction

endpackage

// File: rtl/issue_timeout_ctr.sv
// Clearable up-counter with a terminal-count flag.
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   clr       synchronous clear to 0 (wins over en)
//   en        count enable; the counter holds once it reaches LIMIT-1
//   tc        high while the count equals LIMIT-1
module issue_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      // Saturating: the owner leaves the counting state at terminal count,
      // so the count never wraps.
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/issue_ctrl.sv
// Per-core instruction issue controller. Accepts one decoded instruction,
// routes it to the ALU, load or store unit, holds that unit's start until
// its end is seen, drains the stale end flag, then presents the result on
// a valid/ready response port. A timeout aborts units that never finish.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   instr_valid/instr_ready       instruction handshake (ready only in IDLE)
//   instr_op/a/b/addr             decoded instruction
//   alu_op/a/b, start/end/result  ALU interface (operands held between ops)
//   ld_addr, start/end/result     load unit interface
//   st_addr, st_data, start/end   store unit interface (st_data = operand a)
//   rsp_valid/rsp_ready           response handshake
//   rsp_data/op/err               response payload
//   busy                          high whenever the controller is not IDLE
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ISSUE_TIMEOUT,
  parameter int DRAIN_MAX      = ISSUE_DRAIN_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  opcode       instr_op,
  input  logic [7:0]  instr_a,
  input  logic [7:0]  instr_b,
  input  logic [11:0] instr_addr,
  output opcode       alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        start_alu,
  input  logic        end_alu,
  input  logic [15:0] result_alu,
  output logic [11:0] ld_addr,
  output logic        start_load,
  input  logic        end_load,
  input  logic [15:0] result_load,
  output logic [11:0] st_addr,
  output logic [7:0]  st_data,
  output logic        start_store,
  input  logic        end_store,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output opcode       rsp_op,
  output logic        rsp_err,
  output logic        busy
);

  issue_state_t state, state_nxt;
  unit_sel_t    sel;
  unit_sel_t    new_sel;
  opcode        op_q;

  logic        accept;
  logic        cap_ok;
  logic        cap_to;
  logic        to_clr, to_en, to_tc;
  logic        dr_clr, dr_en, dr_tc;
  logic        end_sel;
  logic [15:0] result_sel;

  assign new_sel = unit_of(instr_op);

  // End/result of the unit latched at accept time.
  always_comb begin
    end_sel    = 1'b0;
    result_sel = 16'h0000;
    case (sel)
      U_ALU:   begin end_sel = end_alu;   result_sel = result_alu;  end
      U_LOAD:  begin end_sel = end_load;  result_sel = result_load; end
      U_STORE: begin end_sel = end_store; result_sel = 16'h0000;    end
      default: begin end_sel = 1'b0;      result_sel = 16'h0000;    end
    endcase
  end

  issue_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (to_clr),
    .en  (to_en),
    .tc  (to_tc)
  );

  issue_timeout_ctr #(.LIMIT(DRAIN_MAX)) u_drain (
    .clk (clk),
    .rst (rst),
    .clr (dr_clr),
    .en  (dr_en),
    .tc  (dr_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cap_ok    = 1'b0;
    cap_to    = 1'b0;
    to_clr    = 1'b0;
    to_en     = 1'b0;
    dr_clr    = 1'b0;
    dr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          accept    = 1'b1;
          to_clr    = 1'b1;
          state_nxt = WAIT_END;
        end
      end
      WAIT_END: begin
        // End seen on the terminal-count cycle still counts as success.
        if (end_sel) begin
          cap_ok    = 1'b1;
          dr_clr    = 1'b1;
          state_nxt = DRAIN;
        end else if (to_tc) begin
          cap_to    = 1'b1;
          state_nxt = RESP;
        end else begin
          to_en = 1'b1;
        end
      end
      DRAIN: begin
        // Absorbs the ALU's one-cycle stale end and the store unit's sticky
        // finish; leaving on the count limit is not an error.
        if (!end_sel || dr_tc) begin
          state_nxt = RESP;
        end else begin
          dr_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all operand and payload registers are reset, since the execution
  // units and the response consumer can observe them right after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel      <= U_ALU;
      op_q     <= OP_NOP;
      alu_op   <= OP_NOP;
      alu_a    <= 8'h00;
      alu_b    <= 8'h00;
      ld_addr  <= 12'h000;
      st_addr  <= 12'h000;
      st_data  <= 8'h00;
      rsp_data <= 16'h0000;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= instr_op;
        sel  <= new_sel;
        // Only the selected unit's operands update; the others hold.
        case (new_sel)
          U_LOAD: ld_addr <= instr_addr;
          U_STORE: begin
            st_addr <= instr_addr;
            st_data <= instr_a;
          end
          default: begin
            alu_op <= instr_op;
            alu_a  <= instr_a;
            alu_b  <= instr_b;
          end
        endcase
      end
      if (cap_ok) begin
        rsp_data <= result_sel;
        rsp_err  <= 1'b0;
      end else if (cap_to) begin
        rsp_data <= 16'h0000;
        rsp_err  <= 1'b1;
      end
    end
  end

  // Starts decode straight from state so they drop asynchronously on reset.
  assign start_alu   = (state == WAIT_END) && (sel == U_ALU);
  assign start_load  = (state == WAIT_END) && (sel == U_LOAD);
  assign start_store = (state == WAIT_END) && (sel == U_STORE);

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_op      = op_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: behavioural ALU, load and store unit
// models, a table of instruction vectors with expected response timing and
// payload, a response scoreboard, plus back-pressure and mid-op reset.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  opcode       instr_op;
  logic [7:0]  instr_a, instr_b;
  logic [11:0] instr_addr;
  opcode       alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        start_alu, end_alu;
  logic [15:0] result_alu;
  logic [11:0] ld_addr;
  logic        start_load, end_load;
  logic [15:0] result_load;
  logic [11:0] st_addr;
  logic [7:0]  st_data;
  logic        start_store, end_store;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  opcode       rsp_op;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.TIMEOUT_CYCLES(TO), .DRAIN_MAX(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_a     (instr_a),
    .instr_b     (instr_b),
    .instr_addr  (instr_addr),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .start_alu   (start_alu),
    .end_alu     (end_alu),
    .result_alu  (result_alu),
    .ld_addr     (ld_addr),
    .start_load  (start_load),
    .end_load    (end_load),
    .result_load (result_load),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .start_store (start_store),
    .end_store   (end_store),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_op      (rsp_op),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  // ---------------- ALU model: registered end, one stale cycle ----------
  logic [2:0] mcnt;
  logic       stale;

  function automatic logic [2:0] alu_lat_m1(input opcode op);
    case (op)
      OP_MUL, OP_SF1, OP_SF2, OP_SF3, OP_SF4: return 3'd2;
      default:                                return 3'd0;
    endcase
  endfunction

  function automatic logic [15:0] alu_model(input opcode op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {8'h00, a} + {8'h00, b};
      OP_SUB:  return {8'h00, a} - {8'h00, b};
      OP_MUL:  return {8'h00, a} * {8'h00, b};
      OP_SF1:  return {8'h00, a} << 1;
      OP_SF2:  return {8'h00, a} << 2;
      OP_SF3:  return {8'h00, a} << 3;
      OP_SF4:  return {8'h00, a} << 4;
      OP_NOP:  return 16'h0000;
      default: return 16'hBEEF;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt       <= 3'd0;
      stale      <= 1'b0;
      end_alu    <= 1'b0;
      result_alu <= 16'h0000;
    end else if (stale) begin
      end_alu <= 1'b0;
      stale   <= 1'b0;
    end else if (end_alu) begin
      stale <= 1'b1;
    end else if (start_alu) begin
      if (mcnt == alu_lat_m1(alu_op)) begin
        end_alu    <= 1'b1;
        result_alu <= alu_model(alu_op, alu_a, alu_b);
        mcnt       <= 3'd0;
      end else begin
        mcnt <= mcnt + 3'd1;
      end
    end
  end

  // ---------------- Load model: combinational end after ld_lat cycles ---
  logic [3:0] ld_cnt;
  logic [3:0] ld_lat;
  logic [7:0] ld_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) ld_cnt <= 4'd0;
    else      ld_cnt <= start_load ? ld_cnt + 4'd1 : 4'd0;
  end
  assign end_load    = start_load && (ld_cnt == ld_lat);
  assign result_load = end_load ? {8'h00, ld_data} : 16'hDEAD;

  // ---------------- Store model: sticky finish, cleared on accept -------
  logic st_done;
  logic st_clr;
  assign st_clr = instr_valid && instr_ready;
  always @(posedge clk or negedge rst) begin
    if (!rst)             st_done <= 1'b0;
    else if (start_store) st_done <= 1'b1;
    else if (st_clr)      st_done <= 1'b0;
  end
  assign end_store = st_done;

  // ---------------- Vectors and scoreboard ------------------------------
  typedef struct {
    opcode       op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] addr;
    logic [3:0]  ld_lat;
    logic [7:0]  ld_data;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_edge;
    int          exp_start;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    opcode       op;
    logic        err;
  } exp_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    exp_t       e;
    int         k;
    int         edge_n;
    int         st_cyc;
    logic       other;
    logic       got;
    logic [2:0] st;
    logic [2:0] selm;
    selm = (v.op == OP_LOAD) ? 3'b010 : (v.op == OP_STORE) ? 3'b100 : 3'b001;
    @(negedge clk);
    check("ready_idle", {31'd0, instr_ready}, 32'd1);
    instr_op    = v.op;
    instr_a     = v.a;
    instr_b     = v.b;
    instr_addr  = v.addr;
    ld_lat      = v.ld_lat;
    ld_data     = v.ld_data;
    instr_valid = 1'b1;
    sb.push_back('{v.exp_data, v.op, v.exp_err});
    @(posedge clk);  // edge 0: accept
    #1;
    instr_valid = 1'b0;
    k = 0; edge_n = 0; st_cyc = 0; other = 1'b0; got = 1'b0;
    while (!got && k < 40) begin
      st = {start_store, start_load, start_alu};
      if ((st & selm) != 3'b000) st_cyc++;
      if ((st & ~selm) != 3'b000) other = 1'b1;
      @(posedge clk);
      #1;
      k++;
      if (rsp_valid) begin
        got    = 1'b1;
        edge_n = k;
      end
    end
    check("rsp_edge", edge_n, v.exp_edge);
    check("start_cycles", st_cyc, v.exp_start);
    check("other_starts", {31'd0, other}, 32'd0);
    if (got) begin
      e = sb[0];
      check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
      check("rsp_op", {28'd0, rsp_op}, {28'd0, e.op});
      check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      check("busy_resp", {30'd0, busy, instr_ready}, 32'd2);
      if (v.op == OP_LOAD) begin
        check("ld_addr", {20'd0, ld_addr}, {20'd0, v.addr});
      end else if (v.op == OP_STORE) begin
        check("st_addr_data", {12'd0, st_addr, st_data}, {12'd0, v.addr, v.a});
      end else begin
        check("alu_operands", {12'd0, alu_op, alu_a, alu_b}, {12'd0, v.op, v.a, v.b});
      end
      for (int h = 0; h < hold; h++) begin
        instr_valid = 1'b1;
        instr_op    = OP_STORE;
        @(posedge clk);
        #1;
        check("bp_hold", {9'd0, rsp_valid, instr_ready, rsp_err, rsp_op, rsp_data},
              {9'd0, 1'b1, 1'b0, e.err, e.op, e.data});
      end
      instr_valid = 1'b0;
      rsp_ready   = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      void'(sb.pop_front());
      check("rsp_done", {30'd0, rsp_valid, instr_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("single_rsp", {31'd0, rsp_valid}, 32'd0);
      if (selm == 3'b001) check("alu_model_idle", {27'd0, mcnt, stale, end_alu}, 32'd0);
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr_op    = OP_NOP;
    instr_a     = 8'h00;
    instr_b     = 8'h00;
    instr_addr  = 12'h000;
    rsp_ready   = 1'b0;
    ld_lat      = 4'd1;
    ld_data     = 8'h00;

    //          op               a      b      addr    lat    ld_data exp_data  err  edge start
    vecs[0] = '{OP_ADD,          8'd20, 8'd22, 12'h000, 4'd1,  8'h00, 16'd42,   1'b0, 4, 2};
    vecs[1] = '{OP_MUL,          8'd15, 8'd17, 12'h000, 4'd1,  8'h00, 16'd255,  1'b0, 6, 4};
    vecs[2] = '{OP_LOAD,         8'h00, 8'h00, 12'h3A5, 4'd1,  8'hC3, 16'h00C3, 1'b0, 3, 2};
    vecs[3] = '{OP_STORE,        8'h5A, 8'h00, 12'h010, 4'd1,  8'h00, 16'h0000, 1'b0, 5, 2};
    vecs[4] = '{OP_LOAD,         8'h00, 8'h00, 12'h7FF, 4'd15, 8'h99, 16'h0000, 1'b1, 8, 8};
    vecs[5] = '{OP_LOAD,         8'h00, 8'h00, 12'h123, 4'd7,  8'h7E, 16'h007E, 1'b0, 9, 8};
    vecs[6] = '{OP_SUB,          8'd50, 8'd8,  12'h000, 4'd1,  8'h00, 16'd42,   1'b0, 4, 2};
    vecs[7] = '{OP_SF2,          8'h81, 8'h00, 12'h000, 4'd1,  8'h00, 16'h0204, 1'b0, 6, 4};
    vecs[8] = '{OP_NOP,          8'h11, 8'h22, 12'h000, 4'd1,  8'h00, 16'h0000, 1'b0, 4, 2};
    vecs[9] = '{opcode'(4'hE),   8'h33, 8'h44, 12'h000, 4'd1,  8'h00, 16'hBEEF, 1'b0, 4, 2};

    #12;
    check("rst_ready_busy", {30'd0, instr_ready, busy}, 32'd2);
    check("rst_starts_valid", {28'd0, start_alu, start_load, start_store, rsp_valid}, 32'd0);
    check("rst_payload", {15'd0, rsp_err, rsp_data}, 32'd0);
    check("rst_operands", {alu_a, alu_b, 4'd0, ld_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], (i == 6) ? 10 : 0);
    end

    // Reset in the middle of a MUL.
    @(negedge clk);
    instr_op    = OP_MUL;
    instr_a     = 8'd9;
    instr_b     = 8'd9;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mul_started", {31'd0, start_alu}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_starts", {28'd0, start_alu, start_load, start_store, rsp_valid}, 32'd0);
    check("mid_rst_state", {30'd0, instr_ready, busy}, 32'd2);
    check("mid_rst_operands", {16'd0, alu_a, alu_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", {30'd0, instr_ready, busy}, 32'd2);
    run_vec(vecs[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
